// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int unsigned NREG    = 16;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard: reservations set bits, retired writes clear them,
// and issue-stage sources are checked against it with write-port bypass.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [REG_W-1:0]  set_reg,
  input  logic              clr_valid,
  input  logic [REG_W-1:0]  clr_reg,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  output logic              hazard,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            src1_pend, src2_pend;

  // Set is applied after clear so a fresh reservation survives a same-cycle retire.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_reg] = 1'b0;
    if (set_valid && (set_reg != '0)) busy_d[set_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  always_comb begin
    src1_pend = (src1 != '0) && busy_q[src1] && !(clr_valid && (clr_reg == src1));
    src2_pend = (src2 != '0) && busy_q[src2] && !(clr_valid && (clr_reg == src2));
    hazard    = src1_pend | src2_pend;
    busy      = busy_q;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with registered write port.
// Define WB_RR_ARB_EN for round-robin arbitration; default is fixed priority (memory load wins).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned NREG = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*REG_W-1:0]    req_reg,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [REG_W-1:0]         rsv_reg,
  input  logic [REG_W-1:0]         SrcReg1,
  input  logic [REG_W-1:0]         SrcReg2,
  output logic                     hazard,
  output logic                     WriteReg,
  output logic [REG_W-1:0]         DstReg,
  output logic [DATA_W-1:0]        DstData,
  output logic [NREG-1:0]          busy
);

  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic              sel;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, we_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

`ifdef WB_RR_ARB_EN
  logic ptr_q, ptr_d;  // requester favoured when both are valid

  always_comb begin
    grant = '0;
    if (rst) begin
      if (req_valid[REQ_ALU] && req_valid[REQ_MEM]) grant[ptr_q] = 1'b1;
      else                                          grant = req_valid;
    end
  end

  always_comb ptr_d = xfer ? ~sel : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'(REQ_ALU);
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = '0;
    if (rst) begin
      if (req_valid[REQ_MEM])      grant[REQ_MEM] = 1'b1;
      else if (req_valid[REQ_ALU]) grant[REQ_ALU] = 1'b1;
    end
  end
`endif

  always_comb begin
    xfer      = |grant;
    sel       = grant[REQ_MEM];
    sel_reg   = sel ? req_reg[2*REG_W-1:REG_W]    : req_reg[REG_W-1:0];
    sel_data  = sel ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    req_ready = grant;
  end

  // R0 writes are accepted but never reach the register file.
  always_comb begin
    we_d   = xfer && (sel_reg != '0);
    dst_d  = xfer ? sel_reg  : dst_q;
    data_d = xfer ? sel_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      dst_q  <= dst_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    WriteReg = we_q;
    DstReg   = dst_q;
    DstData  = data_q;
  end

  wb_scoreboard u_wb_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (rsv_valid),
    .set_reg   (rsv_reg),
    .clr_valid (we_q),
    .clr_reg   (dst_q),
    .src1      (SrcReg1),
    .src2      (SrcReg2),
    .hazard    (hazard),
    .busy      (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts grants,
// scoreboard state and hazard; write-port expectations are queued and popped a cycle later.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [7:0]  req_reg;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        rsv_valid;
  logic [3:0]  rsv_reg;
  logic [3:0]  SrcReg1, SrcReg2;
  logic        hazard;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_reg   (rsv_reg),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .hazard    (hazard),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .busy      (busy)
  );

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state
  logic        m_ok = 1'b0;
  logic [15:0] m_busy;
  logic        m_we;
  logic [3:0]  m_dst;
  logic [15:0] m_data;
  logic        m_ptr;
  logic [1:0]  last_grant = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_pending(input logic [3:0] s);
    return (s != 4'd0) && m_busy[s] && !(m_we && (m_dst == s));
  endfunction

  function automatic logic [1:0] exp_grant();
    if (!rst) return 2'b00;
`ifdef WB_RR_ARB_EN
    if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
    return req_valid;
`else
    if (req_valid[1]) return 2'b10;
    if (req_valid[0]) return 2'b01;
    return 2'b00;
`endif
  endfunction

  task automatic step();
    wb_exp_t     e, n;
    logic [1:0]  g;
    logic [3:0]  r;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("WriteReg", {31'd0, WriteReg}, {31'd0, e.we});
      check_eq("DstReg", {28'd0, DstReg}, {28'd0, e.dst});
      check_eq("DstData", {16'd0, DstData}, {16'd0, e.data});
    end
    if (m_ok) begin
      check_eq("busy", {16'd0, busy}, {16'd0, m_busy});
      check_eq("hazard", {31'd0, hazard},
               {31'd0, exp_pending(SrcReg1) | exp_pending(SrcReg2)});
    end
    g = exp_grant();
    check_eq("req_ready", {30'd0, req_ready}, {30'd0, g});
    last_grant = g;
    if (!rst) begin
      n      = '{1'b0, 4'd0, 16'd0};
      m_busy = 16'd0;
      m_ptr  = 1'b0;
      m_ok   = 1'b1;
    end else begin
      n = '{1'b0, m_dst, m_data};
      if (g != 2'b00) begin
        r      = g[1] ? req_reg[7:4] : req_reg[3:0];
        n.we   = (r != 4'd0);
        n.dst  = r;
        n.data = g[1] ? req_data[31:16] : req_data[15:0];
        m_ptr  = g[0];
      end
      if (m_we) m_busy[m_dst] = 1'b0;
      if (rsv_valid && (rsv_reg != 4'd0)) m_busy[rsv_reg] = 1'b1;
    end
    m_we   = n.we;
    m_dst  = n.dst;
    m_data = n.data;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [3:0] r0, input logic [3:0] r1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic rv,
                       input logic [3:0] rr, input logic [3:0] s1, input logic [3:0] s2);
    rst       = r;
    req_valid = v;
    req_reg   = {r1, r0};
    req_data  = {d1, d0};
    rsv_valid = rv;
    rsv_reg   = rr;
    SrcReg1   = s1;
    SrcReg2   = s2;
    step();
  endtask

  initial begin
    logic [1:0]  cv;
    logic [3:0]  cr0, cr1;
    logic [15:0] cd0, cd1;
    rst = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_reg = '0; SrcReg1 = '0; SrcReg2 = '0;
    @(posedge clk);
    #1;
    repeat (2) drive(0, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Single ALU write to r3
    drive(1, 2'b01, 3, 0, 16'hBEEF, 16'h0, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Contention on regs 5 and 6
    repeat (4) drive(1, 2'b11, 5, 6, 16'h1111, 16'h2222, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Reserve r7, observe hazard, retire with bypass
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 1, 7, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 7, 0);
    drive(1, 2'b01, 7, 0, 16'h7777, 16'h0, 0, 0, 7, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 7, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 7, 0);

    // Same-cycle set and clear of r4: set wins
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 1, 4, 0, 0);
    drive(1, 2'b01, 4, 0, 16'h4444, 16'h0, 0, 0, 0, 4);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 1, 4, 0, 4);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 4);

    // R0: accepted write without WriteReg, reservation ignored, no hazard
    drive(1, 2'b10, 0, 0, 16'h0, 16'hDEAD, 1, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Mid-transfer reset with busy = 0x0090 and pointer moved off requester 0
    drive(1, 2'b01, 9, 0, 16'h9999, 16'h0, 1, 7, 0, 0);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 7, 4);
    drive(0, 2'b10, 0, 9, 16'h0, 16'hAAAA, 1, 5, 7, 4);
    drive(1, 2'b11, 5, 6, 16'h5555, 16'h6666, 0, 0, 7, 4);
    drive(1, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Randomised traffic; ungranted requests keep their payload
    cv = 2'b00; cr0 = '0; cr1 = '0; cd0 = '0; cd1 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!(cv[0] && !last_grant[0])) begin
        cv[0] = 1'($urandom_range(0, 1));
        cr0   = 4'($urandom_range(0, 7));
        cd0   = 16'($urandom);
      end
      if (!(cv[1] && !last_grant[1])) begin
        cv[1] = 1'($urandom_range(0, 1));
        cr1   = 4'($urandom_range(0, 7));
        cd1   = 16'($urandom);
      end
      drive(($urandom_range(0, 39) != 0), cv, cr0, cr1, cd0, cd1, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters: NREQ = 2, the fixed number of writeback requesters; NREG = 16, the number of architectural registers.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  [NREQ-1:0]  requester n has a pending write (0 = ALU writeback, 1 = memory-load writeback).
REQ-005 req_reg  input  [NREQ*4-1:0]  destination register id, 4 bits per requester.
REQ-006 req_data  input  [NREQ*16-1:0]  write data, 16 bits per requester.
REQ-007 req_ready  output  [NREQ-1:0]  grant; the write transfers when req_valid[n] and req_ready[n] are both high.
REQ-008 rsv_valid  input  1  issue stage reserves a destination register.
REQ-009 rsv_reg  input  4  register id being reserved.
REQ-010 SrcReg1, SrcReg2  input  4 each  register ids being read by issue.
REQ-011 hazard  output  1  a source register has a pending, unwritten result.
REQ-012 WriteReg  output  1  register-file write enable.
REQ-013 DstReg  output  4  register-file write address.
REQ-014 DstData  output  16  register-file write data.
REQ-015 busy  output  16  scoreboard vector, for debug.

Function
REQ-016 Grant rules
- req_ready is combinational.
- At most one bit is high per cycle.
- No bit is high when the corresponding req_valid is low.
REQ-017 A transfer registers req_reg/req_data into DstReg/DstData and sets WriteReg = 1 on the next edge (latency 1 cycle).
REQ-018 With no transfer, WriteReg = 0 next cycle; DstReg and DstData hold their previous values.
REQ-019 A transfer with req_reg = 0 is accepted, but WriteReg stays 0 (R0 is hardwired zero).
REQ-020 Scoreboard set: busy[rsv_reg] is set on the edge after rsv_valid = 1; rsv_reg = 0 never sets a bit.
REQ-021 Scoreboard clear: busy[DstReg] is cleared on the edge following a cycle in which WriteReg = 1.
REQ-022 When a set and a clear target the same register in the same cycle, the set wins (the newer reservation stays pending).
REQ-023 hazard = (busy[SrcReg1] | busy[SrcReg2]), excluding any register with WriteReg = 1 and DstReg equal to it that cycle, because the register file bypasses that write.
REQ-024 SrcReg = 0 never raises hazard.
REQ-025 A requester holding req_valid without a grant must keep req_reg/req_data stable; the block does not buffer ungranted requests.
REQ-026 Writes to a register that is not busy are legal: the write occurs and the scoreboard is unchanged.

Reset
REQ-027 While rst = 0 at the edge:
- WriteReg = 0, DstReg = 0, DstData = 0;
- busy = 0;
- the round-robin pointer selects requester 0.
REQ-028 req_ready is forced to 0 during the reset cycle.
REQ-029 Reset asserted mid-transfer discards the write; WriteReg is 0 on the following cycle.
REQ-030 rsv_valid during reset is ignored.

Configuration
REQ-031 The macro is WB_RR_ARB_EN.
REQ-032 With WB_RR_ARB_EN defined: round-robin arbitration; when both requesters are valid, the one not granted most recently wins; the pointer updates only on a transfer.
REQ-033 Without WB_RR_ARB_EN: fixed priority, requester 1 (memory load) always wins; no pointer flop is present.
REQ-034 A single valid requester is granted immediately in either mode.

Structure
REQ-035 The shared package holds: NREG, NREQ, the register-id width (4), the data width (16), and the requester index constants REQ_ALU = 0 and REQ_MEM = 1.
REQ-036 Exactly one sub-module: wb_scoreboard, which holds the busy vector, set/clear logic and hazard lookup; arbitration and the output registers stay in the top module.

Verification
REQ-037 Reset, then req_valid = 2'b01, reg 3, data 16'hBEEF → req_ready = 01; the next cycle WriteReg = 1, DstReg = 3, DstData = BEEF.
REQ-038 Both requesters valid for 4 cycles (regs 5 and 6) → with WB_RR_ARB_EN grants alternate 10, 01, 10, 01; without it grants are 10 every cycle.
REQ-039 rsv_valid reg 7, then SrcReg1 = 7 → hazard = 1; write reg 7 issued → hazard = 0 in the WriteReg cycle (bypass), and busy[7] = 0 the next cycle.
REQ-040 rsv_valid reg 4 in the same cycle as WriteReg = 1 with DstReg = 4 → busy[4] stays 1.
REQ-041 Transfer with reg 0 → WriteReg = 0; rsv_reg = 0 → busy = 0; SrcReg1 = 0 → hazard = 0.
REQ-042 rst = 0 during a granted transfer with busy = 16'h0090 → next cycle WriteReg = 0, busy = 0, and the round-robin pointer selects requester 0.
